pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage RV64 pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It handles load-use stalls, branches taken in MEM (branch_en & zero_flag held in EX/MEM), and a multi-cycle data-memory req/ready handshake with timeout. It sits beside the pipeline registers and drives their enable and flush inputs.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before error (>=2)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
ifid_rs1, ifid_rs2  in  5 each  source regs of instruction in ID
ifid_uses_rs2  in  1  ID instruction reads rs2
idex_mem_read  in  1  EX instruction is a load
idex_rd, idex_rs1, idex_rs2  in  5 each  EX stage register fields
exmem_reg_write, exmem_mem_read, exmem_mem_write  in  1 each  MEM stage controls
exmem_branch_en, exmem_zero_flag  in  1 each  MEM stage branch resolution
exmem_rd  in  5  MEM stage destination
memwb_reg_write  in  1  WB stage write enable
memwb_rd  in  5  WB stage destination
dmem_ready  in  1  data memory completes access this cycle
pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble on next edge
pc_sel_branch  out  1  PC loads branch target
dmem_req  out  1  data memory request
forward_a, forward_b  out  2 each  00 regfile, 10 EX/MEM result, 01 MEM/WB value
mem_err  out  1  sticky memory timeout
state  out  2  00 INIT, 01 RUN, 10 MEM_WAIT, 11 ERROR
stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset is asynchronous; clock is clk. On reset: state=INIT, wait_cnt=0, mem_err=0, counters=0.
- INIT lasts exactly 1 cycle. All four flushes=1, all enables=0, dmem_req=0. Next state is RUN. This purges X contents of the pipeline registers.
- Outputs are combinational from state and inputs. Defaults: all enables=1, all flushes=0, pc_sel_branch=0.
- RUN, with priority evaluated highest first:
  1. Memory access (exmem_mem_read|exmem_mem_write) with dmem_ready=0: dmem_req=1; pc_en, ifid_en, idex_en and exmem_en=0; memwb_flush=1. Next state MEM_WAIT, wait_cnt=1.
  2. Branch taken (exmem_branch_en & exmem_zero_flag): pc_sel_branch=1; ifid_flush, idex_flush and exmem_flush=1. Flush lasts exactly 1 cycle.
  3. Load-use: idex_mem_read & idex_rd!=0 & (idex_rd==ifid_rs1 | (ifid_uses_rs2 & idex_rd==ifid_rs2)). Then pc_en=0, ifid_en=0, idex_flush=1. Stall lasts 1 cycle.
- A memory access with dmem_ready=1 in RUN completes in 0 wait cycles. dmem_req=1 for that cycle; rules 2 and 3 then apply.
- MEM_WAIT: dmem_req=1, stages frozen as in rule 1, wait_cnt increments.
  - dmem_ready=1: behave as RUN rules 2 and 3 this cycle (the access completes). Next state RUN, wait_cnt=0.
  - No dmem_ready and wait_cnt==MEM_TIMEOUT-1: next state ERROR.
- ERROR: all enables=0, memwb_flush=1, dmem_req=0, mem_err=1. Exit only by reset.
- Forwarding (combinational, all states):
  - forward_a=10 if exmem_reg_write & exmem_rd!=0 & exmem_rd==idex_rs1.
  - Otherwise 01 if memwb_reg_write & memwb_rd!=0 & memwb_rd==idex_rs1.
  - Otherwise 00.
  - forward_b uses identical logic with idex_rs2. EX/MEM takes priority over MEM/WB.
- x0 never triggers stall or forwarding.
- Reset asserted mid-MEM_WAIT: immediate return to INIT, dmem_req drops asynchronously.

Optional Feature:
- Macro HAZARD_PERF_EN, defined: counters are active.
  - stall_cnt increments on every cycle with pc_en=0 in RUN or MEM_WAIT.
  - flush_cnt increments on every branch flush.
  - Both saturate at all-ones and reset to 0.
- Not defined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Release reset -> 1 cycle state=00 with all flushes=1, then state=01 with all enables=1.
- idex_mem_read=1, idex_rd=5, ifid_rs1=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. With idex_rd=0 -> no stall.
- exmem_branch_en=1, exmem_zero_flag=1 -> single cycle of pc_sel_branch=1 and ifid_flush, idex_flush, exmem_flush=1. Same inputs with zero_flag=0 -> no flush.
- exmem_mem_read=1, dmem_ready low for 3 cycles then high -> dmem_req high 4 cycles, enables low 3 cycles, return to RUN. stall_cnt=3 with HAZARD_PERF_EN.
- dmem_ready held low with MEM_TIMEOUT=16 -> state=11 and mem_err=1 after 16 cycles, held until reset.
- exmem_rd=memwb_rd=7, idex_rs1=7, both reg_write=1 -> forward_a=10. Clear exmem_reg_write -> forward_a=01.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV64 pipeline.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic             exmem_reg_write,
  input  logic             exmem_mem_read,
  input  logic             exmem_mem_write,
  input  logic             exmem_branch_en,
  input  logic             exmem_zero_flag,
  input  logic [4:0]       exmem_rd,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_sel_branch,
  output logic             dmem_req,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_INIT     = 2'b00,
    S_RUN      = 2'b01,
    S_MEM_WAIT = 2'b10,
    S_ERROR    = 2'b11
  } state_t;

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic mem_acc, br_taken, load_use, resolve;

  assign mem_acc  = exmem_mem_read | exmem_mem_write;
  assign br_taken = exmem_branch_en & exmem_zero_flag;
  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    pc_sel_branch = 1'b0;
    dmem_req      = 1'b0;
    resolve       = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;

    unique case (state_q)
      S_INIT: begin
        {pc_en, ifid_en, idex_en, exmem_en}              = '0;
        {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
      S_RUN: begin
        if (mem_acc && !dmem_ready) begin
          dmem_req    = 1'b1;
          {pc_en, ifid_en, idex_en, exmem_en} = '0;
          memwb_flush = 1'b1;
          state_d     = S_MEM_WAIT;
          wait_cnt_d  = WC_W'(1);
        end else begin
          dmem_req = mem_acc;
          resolve  = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          resolve    = 1'b1;
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en} = '0;
          memwb_flush = 1'b1;
          if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
            state_d   = S_ERROR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
      end
      default: begin
        {pc_en, ifid_en, idex_en, exmem_en} = '0;
        memwb_flush = 1'b1;
        mem_err_d   = 1'b1;
      end
    endcase

    // Branch and load-use rules share one evaluation for RUN and a completing MEM_WAIT.
    if (resolve) begin
      if (br_taken) begin
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        exmem_flush   = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    forward_a = 2'b00;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == idex_rs1))
      forward_a = 2'b10;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == idex_rs1))
      forward_a = 2'b01;
  end

  always_comb begin
    forward_b = 2'b00;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == idex_rs2))
      forward_b = 2'b10;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == idex_rs2))
      forward_b = 2'b01;
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == S_RUN || state_q == S_MEM_WAIT) && !pc_en && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pc_sel_branch && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
